// File: rtl/wb_write_queue_if.sv
// wb_write_queue_if: producer ports, register-file write port and
// forwarding lookup for wb_write_queue.
//   slave  : the queue itself
//   master : the pipeline / multi-cycle unit / register-file side
interface wb_write_queue_if #(
  parameter int AW = 5,
  parameter int DW = 32
);
  // Port A: in-order WB stage, never back-pressured
  logic          a_valid;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_data;
  // Port M: multi-cycle unit, valid/ready
  logic          m_valid;
  logic          m_ready;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  // Register-file write port
  logic          RegWrite;
  logic [AW-1:0] RdAddr;
  logic [DW-1:0] RdData;
  // Status
  logic [2:0]    count;
  logic          empty;
  // Forwarding lookup
  logic [AW-1:0] q_addr;
  logic          q_hit;
  logic [DW-1:0] q_data;

  modport slave (
    input  a_valid, a_addr, a_data,
    input  m_valid, m_addr, m_data,
    output m_ready,
    output RegWrite, RdAddr, RdData,
    output count, empty,
    input  q_addr,
    output q_hit, q_data
  );

  modport master (
    output a_valid, a_addr, a_data,
    output m_valid, m_addr, m_data,
    input  m_ready,
    input  RegWrite, RdAddr, RdData,
    input  count, empty,
    output q_addr,
    input  q_hit, q_data
  );
endinterface

// File: rtl/wb_write_queue.sv
// wb_write_queue: merges WB-stage results (port A) and multi-cycle results
// (port M) into one in-order register-file write per cycle.
// Pending writes sit in a small circular FIFO; writes to $0 are dropped.
// Optional macro WB_BYPASS_EN adds a combinational forwarding lookup
// (q_addr -> q_hit/q_data) over every not-yet-committed write.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input logic             clk,
  input logic             rst_n,
  wb_write_queue_if.slave bus
);
  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] memAddr [DEPTH];
  logic [DW-1:0] memData [DEPTH];
  logic [PW-1:0] rdPtr, wrPtr;
  logic [2:0]    countReg, countNext;
  logic          regWriteReg;
  logic [AW-1:0] rdAddrReg;
  logic [DW-1:0] rdDataReg;

  logic          mReady, aAcc, mAcc, headValid, pop;
  logic          loadValid;
  logic [AW-1:0] loadAddr;
  logic [DW-1:0] loadData;
  logic          wr0Valid, wr1Valid;
  logic [AW-1:0] wr0Addr, wr1Addr;
  logic [DW-1:0] wr0Data, wr1Data;
  logic [1:0]    nEnq;

  // Circular pointer advance; DEPTH need not be a power of two
  function automatic logic [PW-1:0] ptrAdd(input logic [PW-1:0] p, input int unsigned k);
    int unsigned s;
    s = 32'(p) + k;
    return PW'(s % 32'(DEPTH));
  endfunction

  // One slot always stays free for port A, so M is refused at DEPTH-1
  assign mReady    = rst_n && (countReg < 3'(DEPTH - 1));
  assign aAcc      = bus.a_valid && (bus.a_addr != '0);
  assign mAcc      = bus.m_valid && mReady && (bus.m_addr != '0);
  assign headValid = (countReg != 3'd0);

  // Pick the oldest entry (head, then A, then M) for the output register
  // and compact the rest into up to two tail appends
  always_comb begin
    loadValid = 1'b0;
    loadAddr  = rdAddrReg;
    loadData  = rdDataReg;
    pop       = 1'b0;
    wr0Valid  = 1'b0;
    wr0Addr   = bus.a_addr;
    wr0Data   = bus.a_data;
    wr1Valid  = 1'b0;
    wr1Addr   = bus.m_addr;
    wr1Data   = bus.m_data;
    if (headValid) begin
      loadValid = 1'b1;
      loadAddr  = memAddr[rdPtr];
      loadData  = memData[rdPtr];
      pop       = 1'b1;
      if (aAcc) begin
        wr0Valid = 1'b1;
        wr1Valid = mAcc;
      end else if (mAcc) begin
        wr0Valid = 1'b1;
        wr0Addr  = bus.m_addr;
        wr0Data  = bus.m_data;
      end
    end else if (aAcc) begin
      loadValid = 1'b1;
      loadAddr  = bus.a_addr;
      loadData  = bus.a_data;
      if (mAcc) begin
        wr0Valid = 1'b1;
        wr0Addr  = bus.m_addr;
        wr0Data  = bus.m_data;
      end
    end else if (mAcc) begin
      loadValid = 1'b1;
      loadAddr  = bus.m_addr;
      loadData  = bus.m_data;
    end
    nEnq      = {1'b0, wr0Valid} + {1'b0, wr1Valid};
    countNext = countReg - 3'(pop) + 3'(nEnq);
  end

  // Pointers, occupancy and the registered register-file write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr       <= '0;
      wrPtr       <= '0;
      countReg    <= '0;
      regWriteReg <= 1'b0;
      rdAddrReg   <= '0;
      rdDataReg   <= '0;
    end else begin
      rdPtr       <= ptrAdd(rdPtr, 32'(pop));
      wrPtr       <= ptrAdd(wrPtr, 32'(nEnq));
      countReg    <= countNext;
      regWriteReg <= loadValid;
      if (loadValid) begin
        rdAddrReg <= loadAddr;
        rdDataReg <= loadData;
      end
    end
  end

  // FIFO storage; stale contents are harmless since occupancy gates them
  always_ff @(posedge clk) begin
    if (rst_n && wr0Valid) begin
      memAddr[wrPtr] <= wr0Addr;
      memData[wrPtr] <= wr0Data;
    end
    if (rst_n && wr1Valid) begin
      memAddr[ptrAdd(wrPtr, 32'd1)] <= wr1Addr;
      memData[ptrAdd(wrPtr, 32'd1)] <= wr1Data;
    end
  end

  assign bus.m_ready  = mReady;
  assign bus.RegWrite = regWriteReg;
  assign bus.RdAddr   = rdAddrReg;
  assign bus.RdData   = rdDataReg;
  assign bus.count    = countReg;
  assign bus.empty    = (countReg == 3'd0) && !regWriteReg;

`ifdef WB_BYPASS_EN
  logic          qHit;
  logic [DW-1:0] qData;

  // Youngest match wins: later checks override earlier (older) ones
  always_comb begin
    qHit  = 1'b0;
    qData = '0;
    if (bus.q_addr != '0) begin
      if (regWriteReg && (rdAddrReg == bus.q_addr)) begin
        qHit  = 1'b1;
        qData = rdDataReg;
      end
      for (int k = 0; k < DEPTH; k++) begin
        if ((k < int'(countReg)) && (memAddr[ptrAdd(rdPtr, 32'(k))] == bus.q_addr)) begin
          qHit  = 1'b1;
          qData = memData[ptrAdd(rdPtr, 32'(k))];
        end
      end
      if (aAcc && (bus.a_addr == bus.q_addr)) begin
        qHit  = 1'b1;
        qData = bus.a_data;
      end
      if (mAcc && (bus.m_addr == bus.q_addr)) begin
        qHit  = 1'b1;
        qData = bus.m_data;
      end
    end
  end

  assign bus.q_hit  = qHit;
  assign bus.q_data = qData;
`else
  assign bus.q_hit  = 1'b0;
  assign bus.q_data = '0;
`endif
endmodule

// File: tb/tb_wb_write_queue.sv
// tb_wb_write_queue: directed checks of wb_write_queue with DEPTH=4.
module tb_wb_write_queue;
  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  wb_write_queue_if #(.AW(5), .DW(32)) bus ();

  wb_write_queue #(.DEPTH(4), .AW(5), .DW(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.a_valid = 1'b0; bus.a_addr = '0; bus.a_data = '0;
    bus.m_valid = 1'b0; bus.m_addr = '0; bus.m_data = '0;
  endtask

  int expOut [10] = '{10, 20, 11, 21, 12, 22, 13, 14, 15, 23};
  int expCnt [10] = '{1, 2, 3, 3, 3, 3, 2, 2, 1, 0};
  int expMr  [10] = '{1, 1, 1, 0, 0, 0, 0, 1, 1, 1};

  initial begin
    int mIdx;
    idle();
    bus.q_addr = '0;
    rst_n = 1'b0;

    // Reset state
    step(); step();
    check("rst_regwrite", 32'(bus.RegWrite), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_mready", 32'(bus.m_ready), 0);
    check("rst_rdaddr", 32'(bus.RdAddr), 0);
    rst_n = 1'b1;
    #1 check("rel_mready", 32'(bus.m_ready), 1);
    step();

    // Single A write: visible one cycle later
    bus.a_valid = 1'b1; bus.a_addr = 5'd5; bus.a_data = 32'h11111111;
    step();
    idle();
    check("a1_regwrite", 32'(bus.RegWrite), 1);
    check("a1_rdaddr", 32'(bus.RdAddr), 5);
    check("a1_rddata", bus.RdData, 32'h11111111);
    check("a1_count", 32'(bus.count), 0);
    step();
    check("a1_off", 32'(bus.RegWrite), 0);
    check("a1_hold", 32'(bus.RdAddr), 5);
    check("a1_empty", 32'(bus.empty), 1);

    // Same-cycle A and M: A commits first
    bus.a_valid = 1'b1; bus.a_addr = 5'd3; bus.a_data = 32'hA;
    bus.m_valid = 1'b1; bus.m_addr = 5'd4; bus.m_data = 32'hB;
    #1 check("am_mready", 32'(bus.m_ready), 1);
    step();
    idle();
    check("am_w1_addr", 32'(bus.RdAddr), 3);
    check("am_w1_data", bus.RdData, 32'hA);
    check("am_count", 32'(bus.count), 1);
    check("am_notempty", 32'(bus.empty), 0);
    step();
    check("am_w2_we", 32'(bus.RegWrite), 1);
    check("am_w2_addr", 32'(bus.RdAddr), 4);
    check("am_w2_data", bus.RdData, 32'hB);
    check("am_count2", 32'(bus.count), 0);
    step();
    check("am_off", 32'(bus.RegWrite), 0);

    // M alone into an empty queue
    bus.m_valid = 1'b1; bus.m_addr = 5'd9; bus.m_data = 32'h99;
    step();
    idle();
    check("m1_addr", 32'(bus.RdAddr), 9);
    check("m1_data", bus.RdData, 32'h99);
    step();

    // Saturation: A every cycle, M held valid, stalls while full
    mIdx = 0;
    for (int c = 0; c < 10; c++) begin
      bus.a_valid = (c < 6);
      bus.a_addr  = 5'(10 + c);
      bus.a_data  = 32'hD000_0000 | 32'(10 + c);
      bus.m_valid = (mIdx < 4);
      bus.m_addr  = 5'(20 + mIdx);
      bus.m_data  = 32'hD000_0000 | 32'(20 + mIdx);
      #1 check($sformatf("sat_mready_%0d", c), 32'(bus.m_ready), 32'(expMr[c]));
      if (bus.m_valid && expMr[c] == 1) mIdx++;
      step();
      check($sformatf("sat_we_%0d", c), 32'(bus.RegWrite), 1);
      check($sformatf("sat_addr_%0d", c), 32'(bus.RdAddr), 32'(expOut[c]));
      check($sformatf("sat_data_%0d", c), bus.RdData, 32'hD000_0000 | 32'(expOut[c]));
      check($sformatf("sat_count_%0d", c), 32'(bus.count), 32'(expCnt[c]));
    end
    idle();
    step();
    check("sat_off", 32'(bus.RegWrite), 0);
    check("sat_empty", 32'(bus.empty), 1);

    // Writes to $0 are accepted and dropped
    bus.a_valid = 1'b1; bus.a_addr = 5'd0; bus.a_data = 32'hDEAD;
    bus.m_valid = 1'b1; bus.m_addr = 5'd0; bus.m_data = 32'hBEEF;
    #1 check("z_mready", 32'(bus.m_ready), 1);
    step();
    idle();
    check("z_we", 32'(bus.RegWrite), 0);
    check("z_count", 32'(bus.count), 0);
    check("z_empty", 32'(bus.empty), 1);

    // Forwarding lookup
    bus.a_valid = 1'b1; bus.a_addr = 5'd7; bus.a_data = 32'h1;
    bus.m_valid = 1'b1; bus.m_addr = 5'd7; bus.m_data = 32'h2;
    bus.q_addr  = 5'd7;
    #1;
`ifdef WB_BYPASS_EN
    check("byp_in_hit", 32'(bus.q_hit), 1);
    check("byp_in_data", bus.q_data, 32'h2);
`else
    check("nobyp_hit", 32'(bus.q_hit), 0);
    check("nobyp_data", bus.q_data, 0);
`endif
    step();
    idle();
    #1;
`ifdef WB_BYPASS_EN
    check("byp_q_hit", 32'(bus.q_hit), 1);
    check("byp_q_data", bus.q_data, 32'h2);
    bus.q_addr = 5'd0;
    #1 check("byp_zero", 32'(bus.q_hit), 0);
    bus.q_addr = 5'd9;
    #1 check("byp_miss", 32'(bus.q_hit), 0);
    bus.q_addr = 5'd7;
`else
    check("nobyp_hit2", 32'(bus.q_hit), 0);
`endif
    step();
    check("byp_w2_addr", 32'(bus.RdAddr), 7);
    check("byp_w2_data", bus.RdData, 32'h2);
`ifdef WB_BYPASS_EN
    check("byp_out_data", bus.q_data, 32'h2);
`endif
    step();
    check("byp_gone", 32'(bus.q_hit), 0);
    bus.q_addr = 5'd0;

    // Reset mid-operation discards queued writes
    for (int c = 0; c < 3; c++) begin
      bus.a_valid = 1'b1; bus.a_addr = 5'(1 + 2 * c); bus.a_data = 32'(c);
      bus.m_valid = 1'b1; bus.m_addr = 5'(2 + 2 * c); bus.m_data = 32'(c);
      step();
    end
    idle();
    check("fill_count", 32'(bus.count), 3);
    check("fill_mready", 32'(bus.m_ready), 0);
    rst_n = 1'b0;
    #1 check("mid_rst_mready", 32'(bus.m_ready), 0);
    step();
    check("mid_rst_count", 32'(bus.count), 0);
    check("mid_rst_we", 32'(bus.RegWrite), 0);
    rst_n = 1'b1;
    #1 check("mid_rel_mready", 32'(bus.m_ready), 1);
    step();
    check("post_rst_we1", 32'(bus.RegWrite), 0);
    step();
    check("post_rst_we2", 32'(bus.RegWrite), 0);
    check("post_rst_empty", 32'(bus.empty), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/wb_write_queue.md
Name: wb_write_queue

Overview:
Writeback-side initiator for the 32x32 register file: it generates the single RegWrite/RdAddr/RdData write per cycle that the file consumes. It merges two producers: the in-order pipeline WB stage (port A, always accepted) and a multi-cycle unit such as mult/div or a late load (port M, valid/ready). It holds pending results in a small in-order FIFO, drops $0 writes, and optionally exposes a lookup port so ID-stage forwarding can see writes not yet committed.

Parameters:
DEPTH, 4, FIFO entries excluding the output register; must be >= 2.
AW, 5, register address width.
DW, 32, data width.

Ports:
clk  input  1  core clock; all state updates on posedge.
rst_n  input  1  synchronous active-low reset.
a_valid  input  1  WB stage result valid; never back-pressured.
a_addr  input  AW  WB destination register.
a_data  input  DW  WB result.
m_valid  input  1  multi-cycle unit result valid.
m_ready  output  1  queue can accept port M this cycle.
m_addr  input  AW  multi-cycle destination register.
m_data  input  DW  multi-cycle result.
RegWrite  output  1  register-file write enable; registered.
RdAddr  output  AW  register-file write address; registered.
RdData  output  DW  register-file write data; registered.
count  output  3  FIFO occupancy, 0..DEPTH-1.
empty  output  1  count==0 and RegWrite==0.
q_addr  input  AW  lookup address (WB_BYPASS_EN only).
q_hit  output  1  lookup hit.
q_data  output  DW  lookup data.

Behaviour:
- Reset (rst_n low at posedge): RegWrite=0, RdAddr=0, RdData=0, count=0, read/write pointers=0, and all queued entries are discarded. m_ready is forced to 0 while rst_n is low. Reset asserted mid-operation loses pending writes; this is intended, because the pipeline flushes at the same time.
- m_ready = rst_n && (count < DEPTH-1); combinational from count only, never from m_valid. Handshake on m_valid && m_ready. m_valid held with m_ready=0 must keep m_addr and m_data stable.
- Port A is always accepted. One slot is always reserved for it, so count never exceeds DEPTH-1 and the FIFO never overflows.
- Accepted writes with addr==0 are dropped (the handshake still completes). RegWrite never asserts with RdAddr==0.
- Arrival order each cycle: existing FIFO entries (head first), then A, then M. Writes commit to the register file strictly in this order. A wins over M on a same-cycle tie.
- Each posedge, the output register loads the first entry in that order. If none exists, RegWrite=0 and RdAddr/RdData hold their previous values. The remaining entries append to the FIFO tail.
- Next count = count + accepted non-zero A/M entries - (1 if the FIFO head was consumed).
- Latency: with the FIFO empty, an accepted entry appears on RegWrite/RdAddr/RdData the next cycle. The register file captures it on the following negedge.
- Pointers wrap modulo DEPTH. Full (count==DEPTH-1) with A arriving: head pops and A enqueues, so count is unchanged.
- Same-address duplicates are not merged; both commit in order.

Optional Feature:
WB_BYPASS_EN
- Defined: q_hit=1 when q_addr!=0 and q_addr matches any pending write. Pending writes are: the output register with RegWrite=1, valid FIFO entries, this cycle's accepted A, and this cycle's accepted M.
- q_data comes from the youngest match. Priority: accepted M > A > FIFO tail..head > output register. Fully combinational.
- Undefined: q_hit=0 and q_data=0 constantly; q_addr is unused; no comparator logic.

Test Plan:
1. Reset, then A (addr 5, 0x11111111) at cycle 1 -> RegWrite=1, RdAddr=5, RdData=0x11111111 at cycle 2; RegWrite=0 at cycle 3; empty=1.
2. Same cycle A(3, 0xA) and M(4, 0xB) with m_ready=1 -> cycle+1 writes reg 3, cycle+2 writes reg 4; count peaks at 1.
3. A every cycle plus M every cycle for 6 cycles with DEPTH=4 -> count saturates at 3; m_ready drops to 0 when count=3; commit order matches arrival order; no A lost.
4. A to addr 0 and M to addr 0 -> handshake completes; RegWrite stays 0; count stays 0.
5. WB_BYPASS_EN: queue reg 7 = 0x1, then reg 7 = 0x2; q_addr=7 -> q_hit=1, q_data=0x2. q_addr=0 -> q_hit=0. Without the macro -> q_hit=0.
6. Fill to count=3, assert rst_n=0 for one cycle -> next cycle count=0, RegWrite=0, m_ready=1; no stale writes after release.
